ram_fifo_ctrl: RTL and testbench

- Upstream controller that turns the team's 32x8 single-port RAM into a synchronous FIFO.
- Accepts push and pop requests over a ready handshake, then drives the RAM write/read port (wr_re, addr, data_in).
- Returns read data from the RAM's data_out with a pop_valid qualifier.
- Arbitrates push against pop, because the RAM does exactly one access per clock.

---
 rtl/ram_fifo_pkg.sv | 7 +
 rtl/ram_fifo_ctrl_if.sv | 28 ++
 rtl/ram_port_arb.sv | 26 ++
 rtl/ram_fifo_ctrl.sv | 56 +++++
 tb/tb_ram_fifo_ctrl.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/ram_fifo_pkg.sv
// ram_fifo_pkg: shared geometry for the RAM-backed FIFO, its RAM and the bench
package ram_fifo_pkg;
  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 5;
  localparam int DEPTH   = 2 ** ADDR_W;
  localparam int COUNT_W = ADDR_W + 1;
endpackage

// File: rtl/ram_fifo_ctrl_if.sv
// ram_fifo_ctrl_if: push/pop handshake, status and single-port RAM drive of the FIFO controller
interface ram_fifo_ctrl_if;
  import ram_fifo_pkg::*;
  logic               push;
  logic [DATA_W-1:0]  push_data;
  logic               push_ready;
  logic               pop;
  logic               pop_ready;
  logic               pop_valid;
  logic [DATA_W-1:0]  pop_data;
  logic               full;
  logic               empty;
  logic [COUNT_W-1:0] count;
  logic               ram_wr_re;
  logic [ADDR_W-1:0]  ram_addr;
  logic [DATA_W-1:0]  ram_data_in;
  logic [DATA_W-1:0]  ram_data_out;
  modport master (
    output push, push_data, pop, ram_data_out,
    input  push_ready, pop_ready, pop_valid, pop_data, full, empty, count,
           ram_wr_re, ram_addr, ram_data_in
  );
  modport slave (
    input  push, push_data, pop, ram_data_out,
    output push_ready, pop_ready, pop_valid, pop_data, full, empty, count,
           ram_wr_re, ram_addr, ram_data_in
  );
endinterface

// File: rtl/ram_port_arb.sv
// ram_port_arb: round-robin arbiter sharing the single RAM port between push and pop
module ram_port_arb (
  input  logic clk,
  input  logic rst,
  input  logic i_req_push,
  input  logic i_req_pop,
  input  logic i_can_push,
  input  logic i_can_pop,
  output logic o_rdy_push,
  output logic o_rdy_pop,
  output logic o_gnt_push,
  output logic o_gnt_pop
);
  logic r_prio;
  logic w_conflict;
  assign w_conflict = i_req_push & i_req_pop & i_can_push & i_can_pop;
  assign o_rdy_push = i_can_push & !(i_req_pop & i_can_pop & !r_prio);
  assign o_rdy_pop  = i_can_pop & !(i_req_push & i_can_push & r_prio);
  assign o_gnt_push = i_req_push & o_rdy_push;
  assign o_gnt_pop  = i_req_pop & o_rdy_pop;
  // priority flips only when both sides actually contend, so neither can starve
  always_ff @(posedge clk) begin
    if (!rst) r_prio <= 1'b0;
    else if (w_conflict) r_prio <= !r_prio;
  end
endmodule

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: turns a 32x8 single-port RAM into a synchronous FIFO
module ram_fifo_ctrl
  import ram_fifo_pkg::*;
(
  input logic clk,
  input logic rst,
  ram_fifo_ctrl_if.slave bus
);
  logic [ADDR_W-1:0]  r_wr_ptr;
  logic [ADDR_W-1:0]  r_rd_ptr;
  logic [COUNT_W-1:0] r_count;
  logic               r_pop_valid;
  logic               w_full;
  logic               w_empty;
  logic               w_gnt_push;
  logic               w_gnt_pop;
  assign w_full  = r_count == COUNT_W'(DEPTH);
  assign w_empty = r_count == '0;
  ram_port_arb u_arb (
    .clk        (clk),
    .rst        (rst),
    .i_req_push (bus.push),
    .i_req_pop  (bus.pop),
    .i_can_push (rst & !w_full),
    .i_can_pop  (rst & !w_empty),
    .o_rdy_push (bus.push_ready),
    .o_rdy_pop  (bus.pop_ready),
    .o_gnt_push (w_gnt_push),
    .o_gnt_pop  (w_gnt_pop)
  );
  // RAM drive: a push writes at wr_ptr, anything else reads at rd_ptr (idle reads are harmless)
  always_comb begin
    bus.ram_wr_re   = w_gnt_push;
    bus.ram_addr    = !rst ? '0 : w_gnt_push ? r_wr_ptr : r_rd_ptr;
    bus.ram_data_in = bus.push_data;
    bus.pop_data    = bus.ram_data_out;
    bus.pop_valid   = r_pop_valid;
    bus.full        = w_full;
    bus.empty       = w_empty;
    bus.count       = r_count;
  end
  // pointer/occupancy bookkeeping; pop_valid tracks the RAM's one-cycle read latency
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_pop_valid <= 1'b0;
    end else begin
      r_wr_ptr    <= r_wr_ptr + ADDR_W'(w_gnt_push);
      r_rd_ptr    <= r_rd_ptr + ADDR_W'(w_gnt_pop);
      r_count     <= r_count + COUNT_W'(w_gnt_push) - COUNT_W'(w_gnt_pop);
      r_pop_valid <= w_gnt_pop;
    end
  end
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl: directed checks of the RAM-backed FIFO controller with a behavioural RAM
module tb_ram_fifo_ctrl;
  import ram_fifo_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] r_dout;
  ram_fifo_ctrl_if bus ();
  ram_fifo_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  // team RAM model: registered data_out, reset shares the rst net
  always @(posedge clk) begin
    if (!rst) r_dout <= '0;
    else if (bus.ram_wr_re) mem[bus.ram_addr] <= bus.ram_data_in;
    else r_dout <= mem[bus.ram_addr];
  end
  assign bus.ram_data_out = r_dout;

  task automatic test_reset();
    bus.push = 0; bus.pop = 0; bus.push_data = 0; rst = 0;
    @(negedge clk); @(negedge clk); #1;
    checks++; if (bus.count !== 6'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", bus.count); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL rst_empty got %b exp 1", bus.empty); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL rst_full got %b exp 0", bus.full); end
    checks++; if (bus.push_ready !== 1'b0) begin errors++; $display("FAIL rst_push_ready got %b exp 0", bus.push_ready); end
    checks++; if (bus.pop_valid !== 1'b0) begin errors++; $display("FAIL rst_pop_valid got %b exp 0", bus.pop_valid); end
    checks++; if (bus.ram_wr_re !== 1'b0 || bus.ram_addr !== 5'd0) begin errors++; $display("FAIL rst_ram got wr=%b addr=%0d exp 0/0", bus.ram_wr_re, bus.ram_addr); end
    rst = 1;
  endtask

  task automatic test_full_fill();
    for (int i = 0; i < 32; i++) begin
      @(negedge clk); bus.push = 1; bus.push_data = 8'(i + 1); #1;
      checks++; if (bus.push_ready !== 1'b1 || bus.ram_wr_re !== 1'b1 || bus.ram_addr !== 5'(i)) begin
        errors++; $display("FAIL fill_%0d got rdy=%b wr=%b addr=%0d exp 1/1/%0d", i, bus.push_ready, bus.ram_wr_re, bus.ram_addr, i); end
    end
    @(negedge clk); bus.push_data = 8'h21; #1;
    checks++; if (bus.count !== 6'd32 || bus.full !== 1'b1) begin errors++; $display("FAIL fill_full got count=%0d full=%b exp 32/1", bus.count, bus.full); end
    checks++; if (bus.push_ready !== 1'b0 || bus.ram_wr_re !== 1'b0) begin errors++; $display("FAIL fill_33rd got rdy=%b wr=%b exp 0/0", bus.push_ready, bus.ram_wr_re); end
    @(negedge clk); #1;
    checks++; if (bus.count !== 6'd32) begin errors++; $display("FAIL fill_held got count=%0d exp 32", bus.count); end
    bus.push = 0;
  endtask

  task automatic test_drain();
    for (int i = 0; i <= 32; i++) begin
      @(negedge clk); bus.pop = (i < 32); #1;
      if (i < 32) begin
        checks++; if (bus.pop_ready !== 1'b1 || bus.ram_addr !== 5'(i)) begin errors++; $display("FAIL drain_gnt_%0d got rdy=%b addr=%0d exp 1/%0d", i, bus.pop_ready, bus.ram_addr, i); end
      end
      if (i > 0) begin
        checks++; if (bus.pop_valid !== 1'b1 || bus.pop_data !== 8'(i)) begin errors++; $display("FAIL drain_data_%0d got v=%b d=%h exp 1/%h", i, bus.pop_valid, bus.pop_data, 8'(i)); end
      end
    end
    checks++; if (bus.empty !== 1'b1 || bus.count !== 6'd0) begin errors++; $display("FAIL drain_empty got empty=%b count=%0d exp 1/0", bus.empty, bus.count); end
  endtask

  task automatic test_conflict();
    logic [DATA_W-1:0] exp_rest [5];
    exp_rest = '{8'hA2, 8'hA3, 8'hA4, 8'hB0, 8'hB1};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); bus.push = 1; bus.push_data = 8'hA0 + 8'(i);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); bus.push = 1; bus.pop = 1; bus.push_data = 8'hB0 + 8'(k / 2); #1;
      checks++; if (bus.pop_ready !== (k % 2 == 0) || bus.push_ready !== (k % 2 == 1)) begin
        errors++; $display("FAIL conflict_gnt_%0d got pop_rdy=%b push_rdy=%b exp %b/%b", k, bus.pop_ready, bus.push_ready, k % 2 == 0, k % 2 == 1); end
      checks++; if (bus.count !== ((k % 2 == 0) ? 6'd5 : 6'd4)) begin errors++; $display("FAIL conflict_count_%0d got %0d", k, bus.count); end
      if (k % 2 == 1) begin
        checks++; if (bus.pop_valid !== 1'b1 || bus.pop_data !== 8'hA0 + 8'(k / 2)) begin errors++; $display("FAIL conflict_data_%0d got v=%b d=%h exp 1/%h", k, bus.pop_valid, bus.pop_data, 8'hA0 + 8'(k / 2)); end
      end
    end
    @(negedge clk); bus.push = 0; bus.pop = 1; #1;
    checks++; if (bus.count !== 6'd5) begin errors++; $display("FAIL conflict_end got count=%0d exp 5", bus.count); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); bus.pop = (i < 4); #1;
      checks++; if (bus.pop_valid !== 1'b1 || bus.pop_data !== exp_rest[i]) begin errors++; $display("FAIL conflict_rest_%0d got v=%b d=%h exp 1/%h", i, bus.pop_valid, bus.pop_data, exp_rest[i]); end
    end
    @(negedge clk); bus.pop = 0; #1;
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL conflict_empty got %b exp 1", bus.empty); end
  endtask

  task automatic test_wrap();
    int got = 0;
    for (int c = 0; c <= 80; c++) begin
      @(negedge clk); bus.push = (c % 2 == 0) && (c < 80); bus.pop = (c % 2 == 1);
      bus.push_data = 8'h40 + 8'(c / 2); #1;
      if (bus.push) begin
        checks++; if (bus.push_ready !== 1'b1 || bus.ram_wr_re !== 1'b1 || bus.ram_addr !== 5'(7 + c / 2)) begin
          errors++; $display("FAIL wrap_push_%0d got rdy=%b wr=%b addr=%0d exp 1/1/%0d", c / 2, bus.push_ready, bus.ram_wr_re, bus.ram_addr, 5'(7 + c / 2)); end
      end
      if (bus.pop) begin
        checks++; if (bus.pop_ready !== 1'b1 || bus.ram_wr_re !== 1'b0 || bus.ram_addr !== 5'(7 + c / 2)) begin
          errors++; $display("FAIL wrap_pop_%0d got rdy=%b wr=%b addr=%0d exp 1/0/%0d", c / 2, bus.pop_ready, bus.ram_wr_re, bus.ram_addr, 5'(7 + c / 2)); end
      end
      if (c % 2 == 0 && c > 0) begin
        checks++; if (bus.pop_valid !== 1'b1 || bus.pop_data !== 8'h40 + 8'(c / 2 - 1)) begin
          errors++; $display("FAIL wrap_data_%0d got v=%b d=%h exp 1/%h", c / 2 - 1, bus.pop_valid, bus.pop_data, 8'h40 + 8'(c / 2 - 1)); end
        else got++;
      end
    end
    bus.push = 0; bus.pop = 0;
    checks++; if (got != 40) begin errors++; $display("FAIL wrap_total got %0d exp 40", got); end
  endtask

  task automatic test_illegal();
    @(negedge clk); bus.pop = 1; #1;
    checks++; if (bus.pop_ready !== 1'b0) begin errors++; $display("FAIL empty_pop_ready got %b exp 0", bus.pop_ready); end
    @(negedge clk); #1;
    checks++; if (bus.count !== 6'd0 || bus.pop_valid !== 1'b0 || bus.ram_addr !== 5'd15) begin
      errors++; $display("FAIL empty_pop_state got count=%0d v=%b addr=%0d exp 0/0/15", bus.count, bus.pop_valid, bus.ram_addr); end
    bus.pop = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk); bus.push = 1; bus.push_data = 8'hC0 + 8'(i);
    end
    @(negedge clk); bus.push_data = 8'hEE; #1;
    checks++; if (bus.push_ready !== 1'b0 || bus.ram_wr_re !== 1'b0 || bus.full !== 1'b1) begin
      errors++; $display("FAIL full_push got rdy=%b wr=%b full=%b exp 0/0/1", bus.push_ready, bus.ram_wr_re, bus.full); end
    bus.push = 0;
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 25; i++) begin
      @(negedge clk); bus.pop = 1;
    end
    @(negedge clk); #1;
    checks++; if (bus.count !== 6'd7 || bus.pop_ready !== 1'b1) begin errors++; $display("FAIL midrst_pre got count=%0d rdy=%b exp 7/1", bus.count, bus.pop_ready); end
    @(negedge clk); bus.pop = 0; rst = 0;
    @(negedge clk); #1;
    checks++; if (bus.count !== 6'd0 || bus.pop_valid !== 1'b0) begin errors++; $display("FAIL midrst_state got count=%0d v=%b exp 0/0", bus.count, bus.pop_valid); end
    checks++; if (bus.push_ready !== 1'b0) begin errors++; $display("FAIL midrst_push_ready got %b exp 0", bus.push_ready); end
    @(negedge clk); rst = 1; bus.push = 1; bus.pop = 1; bus.push_data = 8'h55; #1;
    checks++; if (bus.push_ready !== 1'b1 || bus.pop_ready !== 1'b0 || bus.ram_addr !== 5'd0) begin
      errors++; $display("FAIL midrst_after got push_rdy=%b pop_rdy=%b addr=%0d exp 1/0/0", bus.push_ready, bus.pop_ready, bus.ram_addr); end
    @(negedge clk); bus.push = 0; bus.pop = 0;
  endtask

  initial begin
    test_reset();
    test_full_fill();
    test_drain();
    test_conflict();
    test_wrap();
    test_illegal();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
